// File: rtl/sub_top_nios2_qsys_0_cpu_debug_pkg.sv
// Shared types and jdo encodings for the OCI memory access scheduler.
package sub_top_nios2_qsys_0_cpu_debug_pkg;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, DONE} state_e;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MON = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    localparam logic [1:0] OP_ADDR = 2'b00;
    localparam logic [1:0] OP_DATA = 2'b01;

    function automatic logic [37:0] jdo_addr(input logic [8:0] addr);
        return {OP_ADDR, 27'b0, addr};
    endfunction

    // Read commands carry no payload, so the data field is forced to zero.
    function automatic logic [37:0] jdo_data(input logic wr, input logic [31:0] wdata);
        return {OP_DATA, wr, 3'b000, (wr ? wdata : 32'b0)};
    endfunction

endpackage

// File: rtl/sub_top_nios2_qsys_0_cpu_debug_rr_arb.sv
// Round-robin pick starting at a registered pointer; pointer moves past the owner on advance.
module sub_top_nios2_qsys_0_cpu_debug_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] owner_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] gnt_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = PW'((int'(ptr_q) + off) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner_i[i]) ptr_d = PW'((i + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sub_top_nios2_qsys_0_cpu_debug_ocimem_sched.sv
// Shares the debug-slave OCI memory port among NREQ requesters: address strobe, data strobe, wait, done.
module sub_top_nios2_qsys_0_cpu_debug_ocimem_sched
    import sub_top_nios2_qsys_0_cpu_debug_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      req_wr_i,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*32-1:0]   req_wdata_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [NREQ-1:0]      done_o,
    output logic [1:0]           err_o,
    output logic [31:0]          rdata_o,
    output logic [37:0]          jdo_o,
    output logic                 take_action_ocimem_a_o,
    output logic                 take_action_ocimem_b_o,
    input  logic [31:0]          MonDReg_i,
    input  logic                 monitor_ready_i,
    input  logic                 monitor_error_i
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e          state_q;
    logic [NREQ-1:0] grant_q, done_q, gnt_d;
    logic [1:0]      err_q;
    logic [31:0]     rdata_q, wdata_q;
    logic [37:0]     jdo_q;
    logic            a_q, b_q, wr_q;
    logic [7:0]      cnt_q;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    sub_top_nios2_qsys_0_cpu_debug_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .owner_i   (grant_q),
        .advance_i (state_q == DONE),
        .gnt_o     (gnt_d)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_d[i]) begin
                sel_wr    = req_wr_i[i];
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[i*32 +: 32];
            end
        end
    end

    // Strobes, done and jdo default low each cycle so they are single-cycle by construction.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= ERR_OK;
            rdata_q <= '0;
            jdo_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            jdo_q  <= '0;
            case (state_q)
                IDLE: if (|req_i) begin
                    grant_q <= gnt_d;
                    wr_q    <= sel_wr;
                    wdata_q <= sel_wdata;
                    a_q     <= 1'b1;
                    jdo_q   <= jdo_addr(9'(sel_addr));
                    state_q <= ADDR;
                end
                ADDR: begin
                    b_q     <= 1'b1;
                    jdo_q   <= jdo_data(wr_q, wdata_q);
                    state_q <= DATA;
                end
                DATA: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (monitor_error_i) begin
                        err_q   <= ERR_MON;
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else if (monitor_ready_i) begin
                        err_q   <= ERR_OK;
                        if (!wr_q) rdata_q <= MonDReg_i;
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else if (cnt_q == TMO_LAST) begin
                        err_q   <= ERR_TMO;
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o                = grant_q;
    assign done_o                 = done_q;
    assign err_o                  = err_q;
    assign rdata_o                = rdata_q;
    assign jdo_o                  = jdo_q;
    assign take_action_ocimem_a_o = a_q;
    assign take_action_ocimem_b_o = b_q;

endmodule

// File: tb/tb_sub_top_nios2_qsys_0_cpu_debug_ocimem_sched.sv
// Scoreboard bench: a transaction-level model schedules accesses and pushes expectations; a monitor checks DUT output.
module tb_sub_top_nios2_qsys_0_cpu_debug_ocimem_sched;
    localparam int NREQ = 2, AW = 9, TIMEOUT = 8;

    typedef struct {
        int              a_at;
        int              done_at;
        logic [NREQ-1:0] gnt;
        logic [37:0]     jdo_a;
        logic [37:0]     jdo_b;
        logic [1:0]      err;
        logic [31:0]     rdata;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]      req = '0, req_wr = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*32-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      grant, done;
    logic [1:0]           err;
    logic [31:0]          rdata, mon_d = '0;
    logic [37:0]          jdo;
    logic                 ta, tbs, mon_rdy = 1'b0, mon_err = 1'b0;

    sub_top_nios2_qsys_0_cpu_debug_ocimem_sched #(.NREQ(NREQ), .ADDR_W(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .req_wr_i(req_wr), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .grant_o(grant), .done_o(done), .err_o(err), .rdata_o(rdata),
        .jdo_o(jdo), .take_action_ocimem_a_o(ta), .take_action_ocimem_b_o(tbs),
        .MonDReg_i(mon_d), .monitor_ready_i(mon_rdy), .monitor_error_i(mon_err)
    );

    always #5 clk = ~clk;
    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int nchk = 0, nerr = 0;
    exp_t q[$];

    // requester intent and model state
    logic [NREQ-1:0] want = '0;
    logic            wr_w[NREQ];
    logic [AW-1:0]   addr_w[NREQ];
    logic [31:0]     wdata_w[NREQ];
    bit   rnd_mode = 0;
    int   force_idx = -1;
    bit   force_err = 0, force_both = 0;
    logic [31:0] force_data = '0;
    int   next_dec = 1 << 30, ptr_m = 0, n_dec = 0, m_owner = -1, done_at = -1;
    int   w_start = 0, w_len = 0, resp_at = -1;
    bit   resp_err = 0, resp_both = 0;
    logic [31:0] resp_data = '0, rdata_m = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_jdo"}, jdo, 0);
        chk({tag, "_stra"}, ta, 0);
        chk({tag, "_strb"}, tbs, 0);
    endtask

    task automatic new_fields(input int i);
        wr_w[i]    = 1'($urandom);
        addr_w[i]  = AW'($urandom);
        wdata_w[i] = $urandom;
    endtask

    // Runs at the negedge before posedge p: requester intent, then arbitration model, then responder.
    task automatic step();
        int p, o, idx, w;
        bit ee, bb;
        logic [31:0] dv;
        exp_t e;
        p = gcyc;
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (want[i]) begin
                    if (i == m_owner && p > done_at) begin
                        if ($urandom % 2 == 0) want[i] = 1'b0;
                        else if ($urandom % 2 == 0) new_fields(i);
                    end else if ($urandom % 24 == 0) want[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    want[i] = 1'b1;
                    new_fields(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i] = want[i];
            req_wr[i] = wr_w[i];
            req_addr[i*AW +: AW] = addr_w[i];
            req_wdata[i*32 +: 32] = wdata_w[i];
        end
        if (!rst && p == next_dec) begin
            if (|want) begin
                o = -1;
                for (int j = 0; j < NREQ; j++) if (o < 0 && want[(ptr_m + j) % NREQ]) o = (ptr_m + j) % NREQ;
                if (force_idx >= 0) begin
                    idx = force_idx; ee = force_err; bb = force_both; dv = force_data;
                end else begin
                    idx = ($urandom % 4 == 0) ? int'($urandom_range(0, TIMEOUT + 1)) : int'($urandom_range(0, 2));
                    ee = ($urandom % 5 == 0); bb = 1'($urandom); dv = $urandom;
                end
                e.gnt = '0; e.gnt[o] = 1'b1;
                e.a_at = p;
                e.jdo_a = {2'b00, 27'b0, addr_w[o]};
                e.jdo_b = {2'b01, wr_w[o], 3'b000, (wr_w[o] ? wdata_w[o] : 32'h0)};
                if (idx >= TIMEOUT) begin
                    w = TIMEOUT; e.err = 2'b10; resp_at = -1;
                end else begin
                    w = idx + 1; resp_at = p + 3 + idx; e.err = ee ? 2'b01 : 2'b00;
                    if (!ee && !wr_w[o]) rdata_m = dv;
                end
                e.rdata = rdata_m;
                e.done_at = p + 2 + w;
                resp_err = ee; resp_both = bb; resp_data = dv;
                w_start = p + 3; w_len = w; done_at = e.done_at;
                next_dec = p + 4 + w; ptr_m = (o + 1) % NREQ; m_owner = o; n_dec++;
                q.push_back(e);
            end else next_dec = p + 1;
        end
        // Inside the wait window only the planned response appears; elsewhere random noise.
        if (w_len > 0 && p >= w_start && p < w_start + w_len) begin
            mon_rdy = (p == resp_at) && (!resp_err || resp_both);
            mon_err = (p == resp_at) && resp_err;
            mon_d   = (p == resp_at) ? resp_data : $urandom;
        end else begin
            mon_rdy = ($urandom % 3 == 0);
            mon_err = ($urandom % 6 == 0);
            mon_d   = $urandom;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        next_dec = gcyc;
        step();
    endtask

    task automatic wait_done(input int n);
        int target;
        target = n_dec + n;
        for (int t = 0; t < 400; t++) begin
            if (n_dec >= target && gcyc >= done_at + 1) break;
            tick();
        end
    endtask

    // Monitor: checks every sampled cycle against the front expectation.
    initial forever begin
        int s;
        bit has;
        exp_t e;
        @(posedge clk);
        #2;
        if (!rst) begin
            s = gcyc - 1;
            has = (q.size() > 0);
            if (has) e = q[0];
            chk("grant", grant, (has && s >= e.a_at && s <= e.done_at) ? e.gnt : '0);
            if (ta || (has && s == e.a_at)) begin
                chk("strobe_a", ta, has && s == e.a_at);
                if (has) chk("jdo_addr", jdo, e.jdo_a);
            end
            if (tbs || (has && s == e.a_at + 1)) begin
                chk("strobe_b", tbs, has && s == e.a_at + 1);
                if (has) chk("jdo_data", jdo, e.jdo_b);
            end
            if (!ta && !tbs) chk("jdo_idle", jdo, 0);
            if (|done) begin
                if (!has) chk("spurious_done", done, 0);
                else begin
                    chk("done_cycle", s, e.done_at);
                    chk("done_owner", done, e.gnt);
                    chk("err", err, e.err);
                    chk("rdata", rdata, e.rdata);
                    void'(q.pop_front());
                end
            end else if (has && s >= e.done_at) begin
                chk("done_missing", done, e.gnt);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin wr_w[i] = 0; addr_w[i] = '0; wdata_w[i] = '0; end
        #23;
        chk_zero_outputs("reset");
        release_reset();

        // single read, ready in 2nd WAIT cycle
        want = 2'b01; wr_w[0] = 0; addr_w[0] = 9'h0A5;
        force_idx = 1; force_err = 0; force_both = 0; force_data = 32'hDEADBEEF;
        wait_done(1); want = '0; tick();
        // single write: rdata must stay
        want = 2'b10; wr_w[1] = 1; addr_w[1] = 9'h1C3; wdata_w[1] = 32'h12345678;
        force_idx = 0; force_data = 32'hCAFEF00D;
        wait_done(1); want = '0; tick();
        // error and ready together
        want = 2'b01; wr_w[0] = 0; addr_w[0] = 9'h012;
        force_idx = 0; force_err = 1; force_both = 1; force_data = 32'h55AA55AA;
        wait_done(1); want = '0; tick();
        // timeout
        want = 2'b10; wr_w[1] = 0; addr_w[1] = 9'h1FF;
        force_idx = TIMEOUT; force_err = 0; force_both = 0;
        wait_done(1); want = '0; tick();
        // contention: alternating owners
        force_idx = -1;
        want = 2'b11; wr_w[0] = 0; addr_w[0] = 9'h033; wr_w[1] = 1; wdata_w[1] = 32'h0BADC0DE;
        wait_done(4); want = '0; tick();
        // one access by requester 0 moves the pointer to 1
        want = 2'b01; force_idx = 0; force_err = 0; force_data = 32'h01020304;
        wait_done(1); want = '0; tick();
        // reset in WAIT
        want = 2'b01; force_idx = TIMEOUT;
        for (int t = 0; t < 60; t++) begin
            if (n_dec > 0 && q.size() > 0 && gcyc >= w_start + 1) break;
            tick();
        end
        #2 rst = 1'b1;
        q.delete(); done_at = -1; w_len = 0; m_owner = -1; next_dec = 1 << 30; rdata_m = '0;
        #1 chk_zero_outputs("abort");
        tick(); tick();
        want = 2'b11; force_idx = 0;
        release_reset();
        wait_done(1); want = '0; tick();

        // randomized traffic
        force_idx = -1; rnd_mode = 1;
        repeat (1500) tick();
        rnd_mode = 0; want = '0;
        for (int t = 0; t < 200 && gcyc <= done_at + 3; t++) tick();
        tick(); tick();
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
